rom_burst_reader: RTL

- Sequencer that sits directly upstream of the 4-entry combinational ROM.
- Drives the ROM's address and sel inputs and captures the 8-bit data it returns.
- Emits captured words downstream over a valid/ready handshake and keeps a running modulo-256 checksum.
- Turns the ROM's static lookup into a clocked, flow-controlled burst source.

---
 rtl/rom_burst_reader_pkg.sv | 16 +
 rtl/rom_burst_reader.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/rom_burst_reader_pkg.sv
// Shared ROM geometry and the burst-reader state encoding, used by the
// reader, the ROM and their benches.
package rom_burst_reader_pkg;

  localparam int ADDR_W = 2;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/rom_burst_reader.sv
// Clocked burst sequencer in front of a combinational ROM: fetches count words
// from start_addr (wrapping), hands each one downstream and keeps a checksum.
module rom_burst_reader
  import rom_burst_reader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   count,
  input  logic              abort,
  output logic [ADDR_W-1:0] rom_address,
  output logic              rom_sel,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  // Handshake: a word moves downstream on a rising edge where out_valid and
  // out_ready are both 1 and abort is 0; out_data is stable while out_valid=1.

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     rem_q, rem_d;
  logic [ADDR_W-1:0]   rom_address_q, rom_address_d;
  logic                rom_sel_q, rom_sel_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   checksum_q, checksum_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      rem_q         <= '0;
      rom_address_q <= '0;
      rom_sel_q     <= 1'b0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      checksum_q    <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      rem_q         <= rem_d;
      rom_address_q <= rom_address_d;
      rom_sel_q     <= rom_sel_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      checksum_q    <= checksum_d;
    end
  end

  // Outputs are registered, so each branch sets them for the state being entered.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    rem_d         = rem_q;
    rom_address_d = rom_address_q;
    rom_sel_d     = 1'b0;
    out_data_d    = out_data_q;
    out_valid_d   = out_valid_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    checksum_d    = checksum_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          checksum_d = '0;
          if (count != '0) begin
            addr_d        = start_addr;
            rem_d         = count;
            rom_address_d = start_addr;
            rom_sel_d     = 1'b1;
            busy_d        = 1'b1;
            state_d       = ST_FETCH;
          end else begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_FETCH: begin
        if (abort) begin
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          out_data_d  = rom_data;
          out_valid_d = 1'b1;
          checksum_d  = checksum_q + rom_data;
          rem_d       = rem_q - (ADDR_W+1)'(1);
          state_d     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (abort) begin
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = ST_IDLE;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          if (rem_q == '0) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            // Address wraps naturally at DEPTH because it is ADDR_W bits wide.
            addr_d        = addr_q + ADDR_W'(1);
            rom_address_d = addr_q + ADDR_W'(1);
            rom_sel_d     = 1'b1;
            state_d       = ST_FETCH;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign rom_address = rom_address_q;
  assign rom_sel     = rom_sel_q;
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign checksum    = checksum_q;

endmodule
